dot_accumulator: RTL and testbench

Downstream consumer of the multiplier's 64-entry result memory. Requests a block read, sums the streamed products into a widened accumulator (dot product of the operand stream), and presents the sum on a valid/ready output. Sits between the multiplier's memVal read port and the host/result interface.

---
 rtl/dot_accumulator.sv | 166 ++++++++++++++++
 tb/tb_dot_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
// dot_accumulator: requests a block of DEPTH products from the multiplier's
// result memory and sums them into a widened accumulator. The sum is then
// offered on a valid/ready output.
// Optional feature macro: DOT_ACC_MAX_TRACK_EN adds out_max / out_max_idx,
// which report the largest beat of the block and its index (first on ties).
module dot_accumulator #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          VALID_memVal,
    input  logic [N-1:0]                  memVal_data,
    output logic                          EN_blockRead,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N+$clog2(DEPTH)-1:0]    out_sum,
    output logic                          busy,
`ifdef DOT_ACC_MAX_TRACK_EN
    output logic [N-1:0]                  out_max,
    output logic [$clog2(DEPTH)-1:0]      out_max_idx,
`endif
    output logic                          err_drop
);

    localparam int CW = $clog2(DEPTH);
    localparam int SW = N + CW;
    localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_acc;
    logic [SW-1:0]   r_out_sum;
    logic            r_en_block_read;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_err_drop;

    // Incoming product zero-extended to accumulator width, and the running
    // sum including the current beat.
    logic [SW-1:0]   w_beat_ext;
    logic [SW-1:0]   w_acc_sum;

    assign w_beat_ext = {{CW{1'b0}}, memVal_data};
    assign w_acc_sum  = r_acc + w_beat_ext;

    // Main controller: state, beat counter, accumulator and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_acc           <= '0;
            r_out_sum       <= '0;
            r_en_block_read <= 1'b0;
            r_out_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_err_drop      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (VALID_memVal) begin
                        r_err_drop <= 1'b1;
                    end
                    if (enable) begin
                        r_state         <= REQ;
                        r_en_block_read <= 1'b1;
                        r_busy          <= 1'b1;
                    end
                end
                REQ: begin
                    // Request stays asserted until the first beat shows up.
                    if (VALID_memVal) begin
                        r_acc           <= w_beat_ext;
                        r_cnt           <= CW'(1);
                        r_state         <= ACCUM;
                        r_en_block_read <= 1'b0;
                    end
                end
                ACCUM: begin
                    // Gaps in the beat stream are simply waited out.
                    if (VALID_memVal) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_out_sum   <= w_acc_sum;
                            r_cnt       <= '0;
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_acc <= w_acc_sum;
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (VALID_memVal) begin
                        r_err_drop <= 1'b1;
                    end
                    if (r_out_ready_hs(r_out_valid, out_ready)) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    function automatic logic r_out_ready_hs(input logic valid, input logic ready);
        return valid & ready;
    endfunction

    assign EN_blockRead = r_en_block_read;
    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign busy         = r_busy;
    assign err_drop     = r_err_drop;

`ifdef DOT_ACC_MAX_TRACK_EN
    logic [N-1:0]    r_max;
    logic [CW-1:0]   r_max_idx;
    logic [N-1:0]    r_out_max;
    logic [CW-1:0]   r_out_max_idx;
    // Strictly greater keeps the first occurrence on ties.
    logic            w_new_max;

    assign w_new_max = (memVal_data > r_max);

    // Running maximum over the block; published together with the sum.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_max         <= '0;
            r_max_idx     <= '0;
            r_out_max     <= '0;
            r_out_max_idx <= '0;
        end else if (VALID_memVal) begin
            if (r_state == REQ) begin
                r_max     <= memVal_data;
                r_max_idx <= '0;
            end else if (r_state == ACCUM) begin
                if (w_new_max) begin
                    r_max     <= memVal_data;
                    r_max_idx <= r_cnt;
                end
                if (r_cnt == LAST_BEAT) begin
                    r_out_max     <= w_new_max ? memVal_data : r_max;
                    r_out_max_idx <= w_new_max ? r_cnt : r_max_idx;
                end
            end
        end
    end

    assign out_max     = r_out_max;
    assign out_max_idx = r_out_max_idx;
`endif

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed testbench for dot_accumulator. Inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_dot_accumulator;

    localparam int N     = 32;
    localparam int DEPTH = 64;
    localparam int SW    = N + $clog2(DEPTH);

    logic                CLK;
    logic                rst_n;
    logic                enable;
    logic                VALID_memVal;
    logic [N-1:0]        memVal_data;
    logic                EN_blockRead;
    logic                out_valid;
    logic                out_ready;
    logic [SW-1:0]       out_sum;
    logic                busy;
    logic                err_drop;
`ifdef DOT_ACC_MAX_TRACK_EN
    logic [N-1:0]        out_max;
    logic [5:0]          out_max_idx;
`endif

    int checks_cnt;
    int errors_cnt;

    dot_accumulator #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .enable       (enable),
        .VALID_memVal (VALID_memVal),
        .memVal_data  (memVal_data),
        .EN_blockRead (EN_blockRead),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .busy         (busy),
`ifdef DOT_ACC_MAX_TRACK_EN
        .out_max      (out_max),
        .out_max_idx  (out_max_idx),
`endif
        .err_drop     (err_drop)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, obs);
        end
    endtask

    // Beat value for a given pattern and index.
    function automatic logic [N-1:0] beat_val(input int mode, input int i);
        case (mode)
            0: return N'(i + 1);
            1: return 32'hFFFF_FFFF;
            2: return 32'd2;
            default: return (i == 5 || i == 40) ? 32'h8000_0000 : 32'd1;
        endcase
    endfunction

    // Wait (bounded) for the block-read request, then confirm busy.
    task automatic wait_en(input string tag);
        int n;
        n = 0;
        while (EN_blockRead !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_val({tag, "_en_req"}, 64'(EN_blockRead), 64'd1);
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    // Drive nbeats beats; gap_mode 1 inserts i%4 idle cycles after each beat
    // except the last. Checks EN_blockRead stays low once beats are flowing.
    task automatic send_block(input int mode, input int nbeats, input int gap_mode, input bit chk_en);
        for (int i = 0; i < nbeats; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = beat_val(mode, i);
            @(negedge CLK);
            VALID_memVal = 1'b0;
            memVal_data  = '0;
            if (chk_en) check_val("en_low_accum", 64'(EN_blockRead), 64'd0);
            if (gap_mode != 0 && i != nbeats - 1) begin
                for (int g = 0; g < (i % 4); g++) begin
                    @(negedge CLK);
                    if (chk_en) check_val("en_low_gap", 64'(EN_blockRead), 64'd0);
                end
            end
        end
    endtask

    initial begin
        checks_cnt   = 0;
        errors_cnt   = 0;
        rst_n        = 1'b0;
        enable       = 1'b0;
        VALID_memVal = 1'b0;
        memVal_data  = '0;
        out_ready    = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset state
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_sum", 64'(out_sum), 64'd0);
        check_val("rst_en", 64'(EN_blockRead), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_err_drop", 64'(err_drop), 64'd0);
        rst_n = 1'b1;
        @(negedge CLK);
        check_val("idle_en_low", 64'(EN_blockRead), 64'd0);

        // Test 1: beats 1..64 contiguous; request rises one cycle after enable
        enable = 1'b1;
        @(negedge CLK);
        check_val("t1_en_one_cycle", 64'(EN_blockRead), 64'd1);
        send_block(0, 64, 0, 1'b0);
        check_val("t1_out_valid", 64'(out_valid), 64'd1);
        check_val("t1_out_sum", 64'(out_sum), 64'd2080);
        check_val("t1_err_drop", 64'(err_drop), 64'd0);
        check_val("t1_busy_done", 64'(busy), 64'd0);
        @(negedge CLK);
        check_val("t1_valid_drop", 64'(out_valid), 64'd0);
        check_val("t1_en_idle", 64'(EN_blockRead), 64'd0);
        @(negedge CLK);
        check_val("t1_en_reassert", 64'(EN_blockRead), 64'd1);

        // Test 2: all-ones beats, full width without wrap
        wait_en("t2");
        send_block(1, 64, 0, 1'b0);
        check_val("t2_out_valid", 64'(out_valid), 64'd1);
        check_val("t2_out_sum", 64'(out_sum), 64'h3F_FFFF_FFC0);
        @(negedge CLK);

        // Test 3: beats 1..64 with gaps; request low throughout accumulation
        wait_en("t3");
        send_block(0, 64, 1, 1'b1);
        check_val("t3_out_valid", 64'(out_valid), 64'd1);
        check_val("t3_out_sum", 64'(out_sum), 64'd2080);
        @(negedge CLK);

        // Test 4: consumer stalls 10 cycles; a stray beat during DONE
        wait_en("t4");
        out_ready = 1'b0;
        send_block(0, 64, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                VALID_memVal = 1'b1;
                memVal_data  = 32'd5;
            end
            @(negedge CLK);
            VALID_memVal = 1'b0;
            memVal_data  = '0;
            check_val("t4_hold_valid", 64'(out_valid), 64'd1);
            check_val("t4_hold_sum", 64'(out_sum), 64'd2080);
            check_val("t4_hold_en", 64'(EN_blockRead), 64'd0);
        end
        check_val("t4_err_drop", 64'(err_drop), 64'd1);
        out_ready = 1'b1;
        @(negedge CLK);
        check_val("t4_valid_drop", 64'(out_valid), 64'd0);
        check_val("t4_err_sticky", 64'(err_drop), 64'd1);
        @(negedge CLK);
        check_val("t4_en_reassert", 64'(EN_blockRead), 64'd1);

        // Test 5: reset mid-block, then a fresh block of 2s
        wait_en("t5");
        send_block(2, 20, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge CLK);
        check_val("t5_rst_valid", 64'(out_valid), 64'd0);
        check_val("t5_rst_sum", 64'(out_sum), 64'd0);
        check_val("t5_rst_en", 64'(EN_blockRead), 64'd0);
        check_val("t5_rst_busy", 64'(busy), 64'd0);
        check_val("t5_rst_err", 64'(err_drop), 64'd0);
        rst_n = 1'b1;
        @(negedge CLK);
        wait_en("t5b");
        send_block(2, 64, 0, 1'b0);
        check_val("t5_out_valid", 64'(out_valid), 64'd1);
        check_val("t5_out_sum", 64'(out_sum), 64'd128);
        check_val("t5_err_drop", 64'(err_drop), 64'd0);
        @(negedge CLK);

        // Test 6: tied maxima at indices 5 and 40
        wait_en("t6");
        send_block(3, 64, 0, 1'b0);
        check_val("t6_out_valid", 64'(out_valid), 64'd1);
        check_val("t6_out_sum", 64'(out_sum), 64'h1_0000_003E);
`ifdef DOT_ACC_MAX_TRACK_EN
        check_val("t6_out_max", 64'(out_max), 64'h8000_0000);
        check_val("t6_out_max_idx", 64'(out_max_idx), 64'd5);
`endif
        @(negedge CLK);
        check_val("t6_valid_drop", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
